decoder_scan_n: RTL and testbench
=================================

DECODER_SCAN_N -- requirements
Module: decoder_scan_n

Interface
REQ-001 The block SHALL provide parameter N, default 3, meaning the select/index width; the output width is 2^N.
REQ-002 The block SHALL provide parameter DWELL_W, default 4, meaning the dwell counter width.
REQ-003 The block SHALL provide port clk  input  1  rising-edge clock.
REQ-004 The block SHALL provide port reset  input  1  asynchronous active-high reset.
REQ-005 The block SHALL provide port enable  input  1  output enable; 0 forces all outputs low.
REQ-006 The block SHALL provide port mode  input  1  0 = DECODE, 1 = SCAN.
REQ-007 The block SHALL provide port sel  input  N  decode index (DECODE) or load index (SCAN).
REQ-008 The block SHALL provide port load  input  1  single-cycle pulse that loads sel into the scan position.
REQ-009 The block SHALL provide port dwell  input  DWELL_W  cycles-per-step minus one in SCAN.
REQ-010 The block SHALL provide port D  output  2^N  registered one-hot output; D[i] high when idx == i.
REQ-011 The block SHALL provide port idx  output  N  currently decoded index.
REQ-012 The block SHALL provide port wrap  output  1  one-cycle pulse when the scan position wraps from 2^N-1 to 0.

Function
REQ-013 The block SHALL implement states IDLE, DECODE and SCAN, encoded in a registered state variable.
REQ-014 The next state SHALL be IDLE when enable=0, DECODE when enable=1 and mode=0, and SCAN when enable=1 and mode=1, evaluated every cycle.
REQ-015 In IDLE, D SHALL be all zeros and wrap 0 from the cycle after entry; idx, the position and the dwell count SHALL hold.
REQ-016 In DECODE, idx SHALL equal sel sampled at the previous edge, and D SHALL be one-hot of that index (latency 1 cycle).
REQ-017 In SCAN, a dwell counter SHALL count 0..dwell; on the cycle it equals dwell, it SHALL clear and the position SHALL increment modulo 2^N.
REQ-018 With dwell=0 in SCAN, the position SHALL advance every cycle.
REQ-019 wrap SHALL be high for exactly the one cycle in which the position registers 0 after incrementing from 2^N-1; wrap SHALL never assert in DECODE, IDLE, or on a load.
REQ-020 When load=1 in SCAN, the position SHALL take sel and the dwell counter SHALL clear on that edge; load SHALL take priority over increment on the same edge.
REQ-021 load SHALL be ignored in DECODE and IDLE.
REQ-022 On DECODE->SCAN, scanning SHALL start from the last decoded idx with the dwell counter cleared.
REQ-023 On SCAN->DECODE, the output SHALL switch to decode of sel on the next edge.
REQ-024 On IDLE->SCAN, scanning SHALL resume from the held position and dwell count.
REQ-025 A change of dwell mid-step SHALL take effect at the next compare; if the count already exceeds the new dwell, the step SHALL complete when the count wraps through 2^DWELL_W-1 to 0 and then reaches dwell; no special handling is required.
REQ-026 D SHALL be exactly one-hot in DECODE and SCAN and all-zero in IDLE; no other pattern is legal.
REQ-027 All outputs SHALL be driven directly from registers with no combinational path from inputs to outputs.

Reset
REQ-028 Asserting reset SHALL immediately, independent of clk, set state=IDLE, D=0, idx=0, position=0, dwell count=0 and wrap=0.
REQ-029 After reset deassertion, the first rising edge SHALL evaluate REQ-014 normally.
REQ-030 Reset asserted mid-scan SHALL discard the position and dwell progress; scanning SHALL restart at index 0.

Verification (N=3, DWELL_W=4)
REQ-031 The bench SHALL cover DECODE sweep: enable=1, mode=0, sel=0..7 one per cycle -> each cycle after, D = 1<<sel, idx = sel, wrap = 0.
REQ-032 The bench SHALL cover SCAN with dwell=2 from reset: D steps 0x01,0x02,...,0x80 every 3 cycles, then 0x01 with wrap high for 1 cycle, every 24 cycles.
REQ-033 The bench SHALL cover load priority: in SCAN at idx=6, at the final dwell cycle pulse load with sel=2 -> next idx = 2 (not 7), no wrap, dwell restarts.
REQ-034 The bench SHALL cover enable gating: drop enable at idx=5 for 4 cycles -> D = 0x00 during the gap, then re-enable in SCAN -> resumes at idx=5 with the held dwell count.
REQ-035 The bench SHALL cover asynchronous reset mid-scan: assert reset between clock edges at idx=4 -> D = 0x00 and idx = 0 immediately; after release with SCAN, D = 0x01 on the first edge.
REQ-036 The bench SHALL cover dwell=0 with a mode toggle: SCAN advances every cycle; switching to DECODE with sel=3 -> D = 0x08 on the next edge.

Source files
------------

// File: rtl/decoder_scan_n_if.sv
// decoder_scan_n_if -- bundle of control inputs and registered outputs for
// decoder_scan_n.
//   enable    : 0 forces the block idle with all outputs low
//   mode      : 0 = DECODE, 1 = SCAN
//   sel       : decode index (DECODE) or load index (SCAN)
//   load      : single-cycle pulse loading sel into the scan position
//   dwell     : cycles-per-step minus one while scanning
//   D         : registered one-hot output, D[i] high when idx == i
//   idx       : currently decoded index
//   wrap      : one-cycle pulse when the scan position wraps to 0
//   dbg_state : current FSM state (0 = IDLE, 1 = DECODE, 2 = SCAN)
// Handshake: there is none. Inputs are sampled on every rising clk edge and
// every output is valid on every cycle; no valid/ready pair is involved.
interface decoder_scan_n_if #(
   parameter int N       = 3,
   parameter int DWELL_W = 4
);
   logic                enable;
   logic                mode;
   logic [N-1:0]        sel;
   logic                load;
   logic [DWELL_W-1:0]  dwell;
   logic [(1<<N)-1:0]   D;
   logic [N-1:0]        idx;
   logic                wrap;
   logic [1:0]          dbg_state;

   // slave: the decoder itself
   modport slave (
      input  enable, mode, sel, load, dwell,
      output D, idx, wrap, dbg_state
   );

   // master: whatever drives the decoder
   modport master (
      output enable, mode, sel, load, dwell,
      input  D, idx, wrap, dbg_state
   );
endinterface

// File: rtl/decoder_scan_n.sv
// decoder_scan_n -- one-hot decoder with an auto-scanning mode.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : decoder_scan_n_if slave modport (enable, mode, sel, load, dwell
//           in; D, idx, wrap, dbg_state out)
// In DECODE the output is the one-hot of sel one cycle later. In SCAN an
// internal position steps through 0..2^N-1, holding each value for dwell+1
// cycles. idx doubles as the scan position, so it is held in IDLE and a scan
// entered from DECODE starts at the last decoded index. All outputs come
// straight from registers.
module decoder_scan_n #(
   parameter int N       = 3,
   parameter int DWELL_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   decoder_scan_n_if.slave  bus
);

   localparam int W = 1 << N;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        d_q, d_d;
   logic [N-1:0]        idx_q, idx_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic                wrap_q, wrap_d;

   always_comb begin
      if (!bus.enable)
         state_d = IDLE;
      else if (bus.mode)
         state_d = SCAN;
      else
         state_d = DECODE;

      d_d    = d_q;
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;

      case (state_d)
         IDLE: begin
            // position and dwell count are frozen so a later scan resumes
            d_d = '0;
         end
         DECODE: begin
            idx_d = bus.sel;
            cnt_d = '0;
            d_d   = {{(W-1){1'b0}}, 1'b1} << bus.sel;
         end
         SCAN: begin
            if (state_q != SCAN) begin
               // Entry edge: present the held position without stepping, so
               // every step (including the first) lasts dwell+1 cycles.
               idx_d = idx_q;
            end else if (bus.load) begin
               idx_d = bus.sel;
               cnt_d = '0;
            end else if (cnt_q == bus.dwell) begin
               cnt_d  = '0;
               idx_d  = idx_q + 1'b1;
               wrap_d = (idx_q == {N{1'b1}});
            end else begin
               // equality compare only: a dwell lowered below the count is
               // reached after the counter rolls over
               cnt_d = cnt_q + 1'b1;
            end
            d_d = {{(W-1){1'b0}}, 1'b1} << idx_d;
         end
         default: begin
            d_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         d_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.D         = d_q;
   assign bus.idx       = idx_q;
   assign bus.wrap      = wrap_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb_decoder_scan_n -- directed bench for decoder_scan_n (N=3, DWELL_W=4).
// Each driver step applies inputs at a falling edge and queues the outputs
// expected after the following rising edge; the monitor pops and compares
// after every rising edge. Asynchronous reset effects are checked directly.
module tb_decoder_scan_n;

   localparam int N       = 3;
   localparam int DWELL_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DEC  = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;

   logic clk;
   logic reset;

   decoder_scan_n_if #(.N(N), .DWELL_W(DWELL_W)) bus ();

   decoder_scan_n #(.N(N), .DWELL_W(DWELL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   // packed as {D[7:0], idx[2:0], wrap, state[1:0]}
   logic [13:0] exp_q[$];
   string       name_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got D=%02h idx=%0d wrap=%0b st=%0d, want D=%02h idx=%0d wrap=%0b st=%0d",
                  name, act[13:6], act[5:3], act[2], act[1:0],
                  exp[13:6], exp[5:3], exp[2], exp[1:0]);
   endtask

   function automatic logic [13:0] sample();
      return {bus.D, bus.idx, bus.wrap, bus.dbg_state};
   endfunction

   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         logic [13:0] e;
         string       n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, sample(), e);
      end
   end

   // ---------------- driver ----------------
   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic en, input logic md, input logic [2:0] s,
                       input logic ld, input logic [3:0] dw,
                       input logic [7:0] e_d, input logic [2:0] e_idx,
                       input logic e_wrap, input logic [1:0] e_st,
                       input string name);
      bus.enable = en;
      bus.mode   = md;
      bus.sel    = s;
      bus.load   = ld;
      bus.dwell  = dw;
      exp_q.push_back({e_d, e_idx, e_wrap, e_st});
      name_q.push_back(name);
      @(negedge clk);
   endtask

   // Reset pulse asserted mid-cycle; checks the immediate effect, releases
   // at the next falling edge.
   task automatic pulse_reset(input string name);
      #1 reset = 1'b1;
      #1 check(name, sample(), {8'h00, 3'd0, 1'b0, ST_IDLE});
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] ed;
      int         p;
      reset      = 1'b0;
      bus.enable = 1'b0;
      bus.mode   = 1'b0;
      bus.sel    = '0;
      bus.load   = 1'b0;
      bus.dwell  = '0;
      #1 reset = 1'b1;
      #2 check("reset_state", sample(), {8'h00, 3'd0, 1'b0, ST_IDLE});
      @(negedge clk);
      reset = 1'b0;

      // DECODE sweep: D = 1<<sel one cycle later
      for (int s = 0; s < 8; s++) begin
         ed = 8'h01 << s;
         step(1, 0, 3'(s), 0, 0, ed, 3'(s), 0, ST_DEC, "decode_sweep");
      end
      // disable: outputs low, idx held
      step(0, 0, 3'd2, 0, 0, 8'h00, 3'd7, 0, ST_IDLE, "idle_hold");

      // SCAN dwell=2 from reset: each index for 3 cycles, wrap every 24
      pulse_reset("reset_from_idle");
      for (int k = 0; k <= 68; k++) begin
         p  = (k / 3) % 8;
         ed = 8'h01 << p;
         step(1, 1, 3'd0, 0, 4'd2, ed, 3'(p), (k == 24 || k == 48), ST_SCAN, "scan_dw2");
      end
      // at idx=6, final dwell cycle: load sel=2 wins over increment
      step(1, 1, 3'd2, 1, 4'd2, 8'h04, 3'd2, 0, ST_SCAN, "load_priority");
      for (int j = 1; j <= 10; j++) begin
         p  = 2 + j / 3;
         ed = 8'h01 << p;
         step(1, 1, 3'd0, 0, 4'd2, ed, 3'(p), 0, ST_SCAN, "load_dwell_restart");
      end

      // enable gap at idx=5 (dwell count 1); load during the gap is ignored
      step(0, 1, 3'd0, 0, 4'd2, 8'h00, 3'd5, 0, ST_IDLE, "gap");
      step(0, 1, 3'd2, 1, 4'd2, 8'h00, 3'd5, 0, ST_IDLE, "gap_load_ignored");
      step(0, 1, 3'd0, 0, 4'd2, 8'h00, 3'd5, 0, ST_IDLE, "gap");
      step(0, 1, 3'd0, 0, 4'd2, 8'h00, 3'd5, 0, ST_IDLE, "gap");
      step(1, 1, 3'd0, 0, 4'd2, 8'h20, 3'd5, 0, ST_SCAN, "resume_pos");
      step(1, 1, 3'd0, 0, 4'd2, 8'h20, 3'd5, 0, ST_SCAN, "resume_cnt");
      step(1, 1, 3'd0, 0, 4'd2, 8'h40, 3'd6, 0, ST_SCAN, "resume_step");

      // dwell=0 scan from reset, then asynchronous reset at idx=4
      pulse_reset("reset_mid_scan_a");
      for (int k = 0; k <= 4; k++) begin
         ed = 8'h01 << k;
         step(1, 1, 3'd0, 0, 4'd0, ed, 3'(k), 0, ST_SCAN, "scan_dw0");
      end
      pulse_reset("reset_async_idx4");
      step(1, 1, 3'd0, 0, 4'd0, 8'h01, 3'd0, 0, ST_SCAN, "reset_first_edge");
      step(1, 1, 3'd0, 0, 4'd0, 8'h02, 3'd1, 0, ST_SCAN, "scan_dw0");
      step(1, 1, 3'd0, 0, 4'd0, 8'h04, 3'd2, 0, ST_SCAN, "scan_dw0");
      // switch to DECODE with sel=3
      step(1, 0, 3'd3, 0, 4'd0, 8'h08, 3'd3, 0, ST_DEC, "scan_to_decode");
      step(1, 0, 3'd5, 1, 4'd0, 8'h20, 3'd5, 0, ST_DEC, "decode_load_ignored");
      // DECODE->SCAN resumes from last decoded index
      step(1, 1, 3'd0, 0, 4'd0, 8'h20, 3'd5, 0, ST_SCAN, "decode_to_scan");
      step(1, 1, 3'd0, 0, 4'd0, 8'h40, 3'd6, 0, ST_SCAN, "scan_dw0");
      step(1, 1, 3'd0, 0, 4'd0, 8'h80, 3'd7, 0, ST_SCAN, "scan_dw0");
      step(1, 1, 3'd0, 0, 4'd0, 8'h01, 3'd0, 1, ST_SCAN, "wrap_dw0");
      for (int k = 1; k <= 7; k++) begin
         ed = 8'h01 << k;
         step(1, 1, 3'd0, 0, 4'd0, ed, 3'(k), 0, ST_SCAN, "after_wrap");
      end
      // load of 0 from position 7 is not a wrap
      step(1, 1, 3'd0, 1, 4'd0, 8'h01, 3'd0, 0, ST_SCAN, "load_no_wrap");
      step(0, 1, 3'd0, 0, 4'd0, 8'h00, 3'd0, 0, ST_IDLE, "final_idle");

      @(negedge clk);
      total_cnt++;
      if (exp_q.size() == 0)
         pass_cnt++;
      else
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
